// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: resolves memory freeze, branch
// redirect, load-use and halt into per-buffer enables, plus a stall-cycle counter.
//
// state     | meaning
// ----------+---------------------------------------------------------------
// S_RUN     | normal flow; a pending data-memory access may start a freeze
// S_MEMWAIT | data-memory access outstanding; pipeline frozen until mem_done
// S_HALTED  | halt retired in WB; everything held until rst
module pipe_hazard_ctrl #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [2:0]       id_rs1,
   input  logic [2:0]       id_rs2,
   input  logic             id_use1,
   input  logic             id_use2,
   input  logic [2:0]       ex_wr_reg,
   input  logic             ex_wr_en,
   input  logic             ex_mem_rd,
   input  logic             ex_br_taken,
   input  logic             mem_req,
   input  logic             mem_done,
   input  logic             wb_halt,
   output logic             pc_wen,
   output logic             ifid_wen,
   output logic             ifid_flush,
   output logic             idex_wen,
   output logic             idex_bubble,
   output logic             exmem_wen,
   output logic             memwb_bubble,
   output logic             halted,
   output logic [CNT_W-1:0] stall_cnt
);

   typedef enum logic [1:0] {
      S_RUN     = 2'd0,
      S_MEMWAIT = 2'd1,
      S_HALTED  = 2'd2
   } state_t;

   state_t           r_state;
   state_t           w_state_nxt;
   logic             r_halted;
   logic [CNT_W-1:0] r_stall_cnt;
   logic             w_freeze;
   logic             w_load_use;
   logic             w_pc_wen_run;

   assign w_freeze = ((r_state == S_RUN) && mem_req && !mem_done) ||
                     ((r_state == S_MEMWAIT) && !mem_done);

   // R0 is deliberately not exempt: it is an ordinary register in this core.
   assign w_load_use = ex_mem_rd && ex_wr_en &&
                       ((id_use1 && (id_rs1 == ex_wr_reg)) ||
                        (id_use2 && (id_rs2 == ex_wr_reg)));

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_RUN: begin
            if (wb_halt && !w_freeze) w_state_nxt = S_HALTED;
            else if (w_freeze)        w_state_nxt = S_MEMWAIT;
         end
         S_MEMWAIT: begin
            if (wb_halt && !w_freeze) w_state_nxt = S_HALTED;
            else if (mem_done)        w_state_nxt = S_RUN;
         end
         S_HALTED: w_state_nxt = S_HALTED;
         default:  w_state_nxt = S_RUN;
      endcase
   end

   always_comb begin
      pc_wen       = 1'b1;
      ifid_wen     = 1'b1;
      ifid_flush   = 1'b0;
      idex_wen     = 1'b1;
      idex_bubble  = 1'b0;
      exmem_wen    = 1'b1;
      memwb_bubble = 1'b0;
      if (rst) begin
         pc_wen       = 1'b0;
         ifid_wen     = 1'b0;
         idex_wen     = 1'b0;
         exmem_wen    = 1'b0;
         ifid_flush   = 1'b1;
         idex_bubble  = 1'b1;
         memwb_bubble = 1'b1;
      end else if (r_state == S_HALTED) begin
         pc_wen    = 1'b0;
         ifid_wen  = 1'b0;
         idex_wen  = 1'b0;
         exmem_wen = 1'b0;
      end else if (w_freeze) begin
         pc_wen       = 1'b0;
         ifid_wen     = 1'b0;
         idex_wen     = 1'b0;
         exmem_wen    = 1'b0;
         memwb_bubble = 1'b1;
      end else if (ex_br_taken) begin
         // The ID instruction is wrong-path, so any load-use on it is moot.
         ifid_flush  = 1'b1;
         idex_bubble = 1'b1;
      end else if (w_load_use) begin
         pc_wen      = 1'b0;
         ifid_wen    = 1'b0;
         idex_bubble = 1'b1;
      end
   end

   assign w_pc_wen_run = pc_wen;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= S_RUN;
         r_halted    <= 1'b0;
         r_stall_cnt <= '0;
      end else begin
         r_state  <= w_state_nxt;
         r_halted <= (w_state_nxt == S_HALTED);
         if ((r_state != S_HALTED) && !w_pc_wen_run && !(&r_stall_cnt))
            r_stall_cnt <= r_stall_cnt + 1'b1;
      end
   end

   assign halted    = r_halted;
   assign stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed scenarios plus randomized
// traffic, all compared against a rule-level reference model.
module tb_pipe_hazard_ctrl;

   localparam int CNT_W   = 16;
   localparam int CNT_MAX = (1 << CNT_W) - 1;

   // control vector order: pc_wen ifid_wen ifid_flush idex_wen idex_bubble exmem_wen memwb_bubble
   localparam logic [6:0] V_RST    = 7'b0010101;
   localparam logic [6:0] V_HALT   = 7'b0000000;
   localparam logic [6:0] V_FREEZE = 7'b0000001;
   localparam logic [6:0] V_BRANCH = 7'b1111110;
   localparam logic [6:0] V_LU     = 7'b0001110;
   localparam logic [6:0] V_IDLE   = 7'b1101010;

   logic clk = 1'b0;
   logic rst;
   logic [2:0] id_rs1, id_rs2, ex_wr_reg;
   logic id_use1, id_use2, ex_wr_en, ex_mem_rd, ex_br_taken;
   logic mem_req, mem_done, wb_halt;
   logic pc_wen, ifid_wen, ifid_flush, idex_wen, idex_bubble, exmem_wen, memwb_bubble;
   logic halted;
   logic [CNT_W-1:0] stall_cnt;
   logic [6:0] w_ctrl;

   int total = 0;
   int bad   = 0;

   // reference model state
   bit m_wait;
   bit m_halt;
   int m_cnt;

   always #5 clk = ~clk;

   pipe_hazard_ctrl #(.CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst),
      .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use1(id_use1), .id_use2(id_use2),
      .ex_wr_reg(ex_wr_reg), .ex_wr_en(ex_wr_en), .ex_mem_rd(ex_mem_rd),
      .ex_br_taken(ex_br_taken), .mem_req(mem_req), .mem_done(mem_done),
      .wb_halt(wb_halt),
      .pc_wen(pc_wen), .ifid_wen(ifid_wen), .ifid_flush(ifid_flush),
      .idex_wen(idex_wen), .idex_bubble(idex_bubble), .exmem_wen(exmem_wen),
      .memwb_bubble(memwb_bubble), .halted(halted), .stall_cnt(stall_cnt)
   );

   assign w_ctrl = {pc_wen, ifid_wen, ifid_flush, idex_wen, idex_bubble, exmem_wen, memwb_bubble};

   function automatic bit m_freeze();
      return !m_halt && !mem_done && (m_wait || mem_req);
   endfunction

   function automatic bit m_load_use();
      bit hit = 1'b0;
      if (ex_mem_rd && ex_wr_en) begin
         if (id_use1 && id_rs1 == ex_wr_reg) hit = 1'b1;
         if (id_use2 && id_rs2 == ex_wr_reg) hit = 1'b1;
      end
      return hit;
   endfunction

   function automatic logic [6:0] exp_ctrl();
      if (rst)          return V_RST;
      if (m_halt)       return V_HALT;
      if (m_freeze())   return V_FREEZE;
      if (ex_br_taken)  return V_BRANCH;
      if (m_load_use()) return V_LU;
      return V_IDLE;
   endfunction

   task automatic model_update();
      bit f;
      logic [6:0] e;
      if (rst) begin
         m_wait = 0; m_halt = 0; m_cnt = 0;
      end else if (!m_halt) begin
         f = m_freeze();
         e = exp_ctrl();
         if (!e[6] && m_cnt < CNT_MAX) m_cnt++;
         if (wb_halt && !f) m_halt = 1;
         else m_wait = f;
      end
   endtask

   // Advance one clock: the model sees the same inputs the DUT sampled.
   task automatic tick();
      @(posedge clk);
      model_update();
      #1;
   endtask

   task automatic idle_inputs();
      rst = 0; id_rs1 = 0; id_rs2 = 0; id_use1 = 0; id_use2 = 0;
      ex_wr_reg = 0; ex_wr_en = 0; ex_mem_rd = 0; ex_br_taken = 0;
      mem_req = 0; mem_done = 0; wb_halt = 0;
   endtask

   task automatic do_reset();
      idle_inputs();
      rst = 1;
      tick();
      rst = 0;
   endtask

   task automatic test_reset();
      idle_inputs();
      rst = 1;
      mem_req = 1;
      #2;
      total++;
      if (w_ctrl !== V_RST) begin
         bad++; $display("FAIL reset_force ctrl got=%b want=%b", w_ctrl, V_RST);
      end
      tick(); tick();
      #2;
      total++;
      if (halted !== 1'b0 || stall_cnt !== '0) begin
         bad++; $display("FAIL reset_regs halted=%b cnt=%0d want 0/0", halted, stall_cnt);
      end
      idle_inputs();
      #2;
      total++;
      if (w_ctrl !== V_IDLE) begin
         bad++; $display("FAIL reset_release ctrl got=%b want=%b", w_ctrl, V_IDLE);
      end
      tick();
   endtask

   task automatic test_load_use();
      do_reset();
      ex_mem_rd = 1; ex_wr_en = 1; ex_wr_reg = 3; id_rs2 = 3; id_use2 = 1; id_rs1 = 5; id_use1 = 1;
      #2;
      total++;
      if (w_ctrl !== V_LU || w_ctrl !== exp_ctrl()) begin
         bad++; $display("FAIL load_use ctrl got=%b want=%b", w_ctrl, V_LU);
      end
      tick();
      ex_mem_rd = 0;
      #2;
      total++;
      if (w_ctrl !== V_IDLE || stall_cnt !== 16'd1) begin
         bad++; $display("FAIL load_use_after ctrl=%b cnt=%0d want %b/1", w_ctrl, stall_cnt, V_IDLE);
      end
      // R0 gets no exemption
      ex_mem_rd = 1; ex_wr_reg = 0; id_rs1 = 0; id_use1 = 1; id_use2 = 0;
      #2;
      total++;
      if (w_ctrl !== V_LU) begin
         bad++; $display("FAIL load_use_r0 ctrl got=%b want=%b", w_ctrl, V_LU);
      end
      tick();
      // matching register but source not used -> no hazard
      id_use1 = 0;
      #2;
      total++;
      if (w_ctrl !== V_IDLE || stall_cnt !== 16'd2) begin
         bad++; $display("FAIL load_use_unused ctrl=%b cnt=%0d want %b/2", w_ctrl, stall_cnt, V_IDLE);
      end
      tick();
   endtask

   task automatic test_branch_vs_load_use();
      int c0;
      do_reset();
      c0 = m_cnt;
      ex_mem_rd = 1; ex_wr_en = 1; ex_wr_reg = 3; id_rs2 = 3; id_use2 = 1; ex_br_taken = 1;
      #2;
      total++;
      if (w_ctrl !== V_BRANCH) begin
         bad++; $display("FAIL branch_over_lu ctrl got=%b want=%b", w_ctrl, V_BRANCH);
      end
      tick();
      ex_br_taken = 0; ex_mem_rd = 0;
      #2;
      total++;
      if (stall_cnt !== c0[CNT_W-1:0]) begin
         bad++; $display("FAIL branch_cnt got=%0d want=%0d", stall_cnt, c0);
      end
      tick();
   endtask

   task automatic test_mem_wait();
      do_reset();
      mem_req = 1;
      for (int i = 0; i < 3; i++) begin
         #2;
         total++;
         if (w_ctrl !== V_FREEZE) begin
            bad++; $display("FAIL mem_freeze cyc=%0d ctrl got=%b want=%b", i, w_ctrl, V_FREEZE);
         end
         tick();
      end
      mem_done = 1;
      ex_br_taken = 1;
      #2;
      total++;
      if (w_ctrl !== V_BRANCH) begin
         bad++; $display("FAIL mem_release ctrl got=%b want=%b", w_ctrl, V_BRANCH);
      end
      tick();
      mem_req = 0; mem_done = 0; ex_br_taken = 0;
      #2;
      total++;
      if (w_ctrl !== V_IDLE || stall_cnt !== 16'd3) begin
         bad++; $display("FAIL mem_after ctrl=%b cnt=%0d want %b/3", w_ctrl, stall_cnt, V_IDLE);
      end
      // req and done together in RUN: no freeze, no MEMWAIT
      mem_req = 1; mem_done = 1;
      #2;
      total++;
      if (w_ctrl !== V_IDLE) begin
         bad++; $display("FAIL mem_same_cycle ctrl got=%b want=%b", w_ctrl, V_IDLE);
      end
      tick();
      mem_req = 0; mem_done = 0;
      #2;
      total++;
      if (w_ctrl !== V_IDLE || stall_cnt !== 16'd3) begin
         bad++; $display("FAIL mem_same_after ctrl=%b cnt=%0d want %b/3", w_ctrl, stall_cnt, V_IDLE);
      end
      tick();
   endtask

   task automatic test_halt_in_memwait();
      do_reset();
      mem_req = 1;
      tick();
      wb_halt = 1;
      #2;
      total++;
      if (w_ctrl !== V_FREEZE) begin
         bad++; $display("FAIL halt_frozen ctrl got=%b want=%b", w_ctrl, V_FREEZE);
      end
      tick();
      #2;
      total++;
      if (halted !== 1'b0) begin
         bad++; $display("FAIL halt_ignored halted got=%b want=0", halted);
      end
      mem_done = 1;
      tick();
      mem_req = 0; mem_done = 0; wb_halt = 0;
      for (int i = 0; i < 4; i++) begin
         mem_req = 1'($urandom); ex_br_taken = 1'($urandom);
         #2;
         total++;
         if (w_ctrl !== V_HALT || halted !== 1'b1 || stall_cnt !== m_cnt[CNT_W-1:0] || m_cnt != 2) begin
            bad++; $display("FAIL halted_hold ctrl=%b halted=%b cnt=%0d want %b/1/2", w_ctrl, halted, stall_cnt, V_HALT);
         end
         tick();
      end
      rst = 1;
      tick();
      idle_inputs();
      #2;
      total++;
      if (halted !== 1'b0 || w_ctrl !== V_IDLE) begin
         bad++; $display("FAIL halt_reset halted=%b ctrl=%b want 0/%b", halted, w_ctrl, V_IDLE);
      end
      tick();
   endtask

   task automatic test_reset_mid_wait();
      do_reset();
      mem_req = 1;
      tick(); tick();
      rst = 1;
      tick();
      idle_inputs();
      #2;
      total++;
      if (w_ctrl !== V_IDLE || stall_cnt !== '0 || halted !== 1'b0) begin
         bad++; $display("FAIL reset_mid_wait ctrl=%b cnt=%0d halted=%b want %b/0/0", w_ctrl, stall_cnt, halted, V_IDLE);
      end
      tick();
   endtask

   task automatic test_random();
      logic [6:0] e;
      do_reset();
      for (int i = 0; i < 600; i++) begin
         rst         = ($urandom_range(0, 39) == 0);
         id_rs1      = 3'($urandom_range(0, 3));
         id_rs2      = 3'($urandom_range(0, 3));
         ex_wr_reg   = 3'($urandom_range(0, 3));
         id_use1     = 1'($urandom);
         id_use2     = 1'($urandom);
         ex_wr_en    = ($urandom_range(0, 3) != 0);
         ex_mem_rd   = 1'($urandom);
         ex_br_taken = ($urandom_range(0, 4) == 0);
         mem_req     = ($urandom_range(0, 3) == 0);
         mem_done    = ($urandom_range(0, 2) == 0);
         wb_halt     = ($urandom_range(0, 29) == 0);
         #2;
         e = exp_ctrl();
         total++;
         if (w_ctrl !== e || halted !== m_halt || stall_cnt !== m_cnt[CNT_W-1:0]) begin
            bad++;
            $display("FAIL random cyc=%0d ctrl=%b/%b halted=%b/%b cnt=%0d/%0d (got/want)",
                     i, w_ctrl, e, halted, m_halt, stall_cnt, m_cnt);
         end
         tick();
      end
   endtask

   task automatic test_saturation();
      do_reset();
      mem_req = 1;
      for (int i = 0; i < CNT_MAX + 5; i++) tick();
      #2;
      total++;
      if (stall_cnt !== 16'hFFFF || m_cnt != CNT_MAX) begin
         bad++; $display("FAIL saturate cnt got=%0h want=ffff", stall_cnt);
      end
      tick();
      #2;
      total++;
      if (stall_cnt !== 16'hFFFF || w_ctrl !== V_FREEZE) begin
         bad++; $display("FAIL saturate_hold cnt=%0h ctrl=%b want ffff/%b", stall_cnt, w_ctrl, V_FREEZE);
      end
      tick();
   endtask

   initial begin
      idle_inputs();
      m_wait = 0; m_halt = 0; m_cnt = 0;
      #1;
      test_reset();
      test_load_use();
      test_branch_vs_load_use();
      test_mem_wait();
      test_halt_in_memwait();
      test_reset_mid_wait();
      test_random();
      test_saturation();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
